// File: rtl/puf_resp_ctrl_if.sv
// rtl/puf_resp_ctrl_if.sv - run control, ring-oscillator select and response signals of puf_resp_ctrl
interface puf_resp_ctrl_if #(
  parameter int N_BITS = 16
) ();
  logic              start;
  logic              abort;
  logic [7:0]        chal_seed;
  logic              cmp_bit;
  logic [7:0]        sel1;
  logic [7:0]        sel2;
  logic              ro_enable;
  logic              cnt_reset;
  logic              busy;
  logic              done;
  logic [N_BITS-1:0] response;
  logic              resp_valid;

  // Requester / measurement-stage side
  modport master (
    output start, abort, chal_seed, cmp_bit,
    input  sel1, sel2, ro_enable, cnt_reset, busy, done, response, resp_valid
  );

  // Controller side
  modport slave (
    input  start, abort, chal_seed, cmp_bit,
    output sel1, sel2, ro_enable, cnt_reset, busy, done, response, resp_valid
  );
endinterface

// File: rtl/puf_resp_ctrl.sv
// rtl/puf_resp_ctrl.sv - ring-oscillator PUF sequencer: per-bit clear/measure/capture, response collection
module puf_resp_ctrl #(
  parameter int N_BITS     = 16,
  parameter int WIN_CYC    = 1024,
  parameter int SETTLE_CYC = 4
) (
  input  logic           clk,
  input  logic           reset,
  puf_resp_ctrl_if.slave bus
);

  localparam int IW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int CMAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] WIN_LAST    = CW'(WIN_CYC - 1);
  localparam logic [IW-1:0] I_LAST      = IW'(N_BITS - 1);

  logic [2:0]        state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [7:0]        seed, seed_nxt;
  logic [N_BITS-1:0] shadow, shadow_nxt;
  logic              accept;
  logic              finish;
  logic [6:0]        idx7;
  logic [6:0]        sel_base;

  assign accept = (state == S_IDLE) && bus.start;
  assign finish = (state == S_DONE) && !bus.abort;

  // Selects for the pair being entered; 7-bit wrap keeps sel2 = sel1 + 1 distinct from sel1
  assign idx7     = 7'(idx_nxt);
  assign sel_base = seed_nxt[6:0] + {idx7[5:0], 1'b0};

  // Next-state, phase counter, bit index and shadow response; abort overrides every transition
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    seed_nxt   = seed;
    shadow_nxt = shadow;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          seed_nxt   = bus.chal_seed;
          idx_nxt    = '0;
          shadow_nxt = '0;
          cnt_nxt    = '0;
          state_nxt  = S_CLR;
        end
      end
      S_CLR: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (cnt == WIN_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_CAPT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_CAPT: begin
        if (cnt == SETTLE_LAST) begin
          shadow_nxt[idx] = bus.cmp_bit;
          cnt_nxt         = '0;
          state_nxt       = S_NEXT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_NEXT: begin
        if (idx == I_LAST) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = S_CLR;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end
  end

  // State registers plus outputs decoded from the next state so each output is registered yet aligned with its state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      idx            <= '0;
      seed           <= '0;
      shadow         <= '0;
      bus.sel1       <= '0;
      bus.sel2       <= '0;
      bus.ro_enable  <= 1'b0;
      bus.cnt_reset  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.response   <= '0;
      bus.resp_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      idx           <= idx_nxt;
      seed          <= seed_nxt;
      shadow        <= shadow_nxt;
      bus.busy      <= (state_nxt != S_IDLE);
      bus.ro_enable <= (state_nxt == S_RUN);
      bus.cnt_reset <= (state_nxt == S_CLR);
      bus.done      <= finish;
      if ((state_nxt == S_CLR) && (state != S_CLR)) begin
        bus.sel1 <= {1'b0, sel_base};
        bus.sel2 <= {1'b0, sel_base + 7'd1};
      end
      if (accept) begin
        bus.resp_valid <= 1'b0;
      end else if (finish) begin
        bus.response   <= shadow;
        bus.resp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_puf_resp_ctrl.sv
// tb/tb_puf_resp_ctrl.sv - self-checking bench for puf_resp_ctrl with N_BITS=4, WIN_CYC=8, SETTLE_CYC=2
module tb_puf_resp_ctrl;
  localparam int N_BITS     = 4;
  localparam int WIN_CYC    = 8;
  localparam int SETTLE_CYC = 2;
  localparam int BIT_CYC    = 2 * SETTLE_CYC + WIN_CYC + 1;
  localparam int DONE_CYC   = N_BITS * BIT_CYC + 1;

  typedef struct {
    logic [7:0]      seed;
    logic [3:0]      pat;
    logic [3:0]      resp;
    logic [3:0][7:0] sel1;
    logic [3:0][7:0] sel2;
  } vec_t;

  typedef struct {
    logic [3:0] resp;
    int         done_cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  int     checks = 0;
  int     errors = 0;
  vec_t   vec[4];
  exp_t   sb_q[$];

  puf_resp_ctrl_if #(.N_BITS(N_BITS)) bus ();

  puf_resp_ctrl #(
    .N_BITS(N_BITS), .WIN_CYC(WIN_CYC), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop so the bench can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    check(name, {bus.sel1, bus.sel2, bus.ro_enable, bus.cnt_reset, bus.busy,
                 bus.done, bus.response, bus.resp_valid}, 64'd0);
  endtask

  task automatic run_vec(input int v);
    exp_t       e;
    int         ro_cnt, cr_cnt, mid_bad, phase_bad, ph, b;
    bit         seen;
    logic [3:0] prev;
    prev          = bus.response;
    e.resp        = vec[v].resp;
    e.done_cyc    = DONE_CYC;
    sb_q.push_back(e);
    bus.chal_seed = vec[v].seed;
    bus.cmp_bit   = vec[v].pat[0];
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    ro_cnt = 0; cr_cnt = 0; mid_bad = 0; phase_bad = 0; seen = 1'b0;
    for (int c = 0; c < DONE_CYC + 10 && !seen; c++) begin
      ph = c % BIT_CYC;
      b  = c / BIT_CYC;
      if (ph == 0 && b < N_BITS) begin
        check($sformatf("v%0d_sel1_b%0d", v, b), bus.sel1, vec[v].sel1[b]);
        check($sformatf("v%0d_sel2_b%0d", v, b), bus.sel2, vec[v].sel2[b]);
      end
      if (bus.ro_enable) ro_cnt++;
      if (bus.cnt_reset) cr_cnt++;
      if (b < N_BITS) begin
        if (ph == 1 && !(bus.cnt_reset && !bus.ro_enable)) phase_bad++;
        if (ph == 2 && !(bus.ro_enable && !bus.cnt_reset)) phase_bad++;
        if (ph == 2 * SETTLE_CYC + WIN_CYC - 1 && (bus.ro_enable || bus.cnt_reset)) phase_bad++;
      end
      if (bus.done) begin
        seen = 1'b1;
        check($sformatf("v%0d_sb_pending", v), sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check($sformatf("v%0d_done_cycle", v), c, e.done_cyc);
          check($sformatf("v%0d_response", v), bus.response, e.resp);
        end
        check($sformatf("v%0d_resp_valid", v), bus.resp_valid, 1);
        check($sformatf("v%0d_busy_at_done", v), bus.busy, 0);
      end else begin
        if (bus.response !== prev || bus.resp_valid !== 1'b0 || bus.busy !== 1'b1) mid_bad++;
        bus.cmp_bit = vec[v].pat[((c + 1) / BIT_CYC) % N_BITS];
        tick();
      end
    end
    check($sformatf("v%0d_done_seen", v), seen, 1);
    check($sformatf("v%0d_ro_cycles", v), ro_cnt, N_BITS * WIN_CYC);
    check($sformatf("v%0d_clr_cycles", v), cr_cnt, N_BITS * SETTLE_CYC);
    check($sformatf("v%0d_phase_errs", v), phase_bad, 0);
    check($sformatf("v%0d_mid_run_errs", v), mid_bad, 0);
    tick();
    check($sformatf("v%0d_done_one_cycle", v), bus.done, 0);
    check($sformatf("v%0d_resp_hold", v), bus.response, vec[v].resp);
  endtask

  initial begin
    int busy_low, dones;
    exp_t e;

    vec[0] = '{seed: 8'h10, pat: 4'b1101, resp: 4'b1101,
               sel1: {8'h16, 8'h14, 8'h12, 8'h10}, sel2: {8'h17, 8'h15, 8'h13, 8'h11}};
    vec[1] = '{seed: 8'h7F, pat: 4'b1010, resp: 4'b1010,
               sel1: {8'h05, 8'h03, 8'h01, 8'h7F}, sel2: {8'h06, 8'h04, 8'h02, 8'h00}};
    vec[2] = '{seed: 8'h3E, pat: 4'b0010, resp: 4'b0010,
               sel1: {8'h44, 8'h42, 8'h40, 8'h3E}, sel2: {8'h45, 8'h43, 8'h41, 8'h3F}};
    vec[3] = '{seed: 8'hFE, pat: 4'b0110, resp: 4'b0110,
               sel1: {8'h04, 8'h02, 8'h00, 8'h7E}, sel2: {8'h05, 8'h03, 8'h01, 8'h7F}};

    bus.start = 1'b0; bus.abort = 1'b0; bus.chal_seed = 8'h00; bus.cmp_bit = 1'b0;
    repeat (3) tick();
    check_zero("reset_outputs");
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("idle_after_reset_busy", bus.busy, 0);

    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_in_idle_busy", bus.busy, 0);

    for (int v = 0; v < 4; v++) run_vec(v);

    // Abort during RUN of bit 2
    bus.chal_seed = 8'h10; bus.cmp_bit = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 30; c++) tick();
    check("abort_pre_ro", bus.ro_enable, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_ro", bus.ro_enable, 0);
    check("abort_clr", bus.cnt_reset, 0);
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.done) dones++;
      tick();
    end
    check("abort_no_done", dones, 0);
    check("abort_resp_valid", bus.resp_valid, 0);
    check("abort_resp_kept", bus.response, vec[3].resp);

    // Reset asserted during CAPT of bit 1
    bus.chal_seed = 8'h10; bus.cmp_bit = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 2 * BIT_CYC - 3; c++) tick();
    check("capt_busy", bus.busy, 1);
    check("capt_ro", bus.ro_enable, 0);
    #2 reset = 1'b0;
    #1;
    check_zero("async_reset_outputs");
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("no_restart_after_reset", bus.busy, 0);
    run_vec(0);

    // start held high for 60 cycles
    e.resp = vec[0].resp;
    e.done_cyc = DONE_CYC;
    sb_q.push_back(e);
    bus.chal_seed = vec[0].seed; bus.cmp_bit = vec[0].pat[0]; bus.start = 1'b1;
    tick();
    busy_low = 0; dones = 0;
    for (int c = 0; c < 60; c++) begin
      if (c < DONE_CYC && !bus.busy) busy_low++;
      if (bus.done) begin
        dones++;
        check("held_sb_pending", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("held_done_cycle", c, e.done_cyc);
          check("held_response", bus.response, e.resp);
        end
      end
      if (c == DONE_CYC) begin
        check("held_valid_at_done", bus.resp_valid, 1);
        check("held_idle_at_done", bus.busy, 0);
      end
      if (c == DONE_CYC + 1) begin
        check("held_second_busy", bus.busy, 1);
        check("held_second_valid_drop", bus.resp_valid, 0);
      end
      bus.cmp_bit = vec[0].pat[((c + 1) / BIT_CYC) % N_BITS];
      if (c == 59) bus.start = 1'b0;
      tick();
    end
    check("held_busy_gaps", busy_low, 0);
    check("held_done_count", dones, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("held_abort_idle", bus.busy, 0);

    // start and abort together in IDLE: start wins
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_beats_abort", bus.busy, 1);
    tick();
    bus.abort = 1'b0;
    check("abort_after_accept", bus.busy, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/puf_resp_ctrl.md
PUF_RESP_CTRL -- requirements
Module: puf_resp_ctrl

Interface
REQ-001 Parameter N_BITS, default 16: response length and number of challenge pairs evaluated per run; range 1..64.
REQ-002 Parameter WIN_CYC, default 1024: ring-oscillator measurement window in clk cycles; at least 1.
REQ-003 Parameter SETTLE_CYC, default 4: counter-clear and comparator-settle time in clk cycles; at least 1.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: run request, sampled only in IDLE.
REQ-007 Port abort, input, 1 bit: synchronous run cancel.
REQ-008 Port chal_seed, input, 8 bits: challenge seed, captured when start is accepted.
REQ-009 Port cmp_bit, input, 1 bit: comparator result from the counter/compare stage; 1 means bank-2 count > bank-1 count.
REQ-010 Port sel1, output, 8 bits: bank-1 ring-oscillator mux select.
REQ-011 Port sel2, output, 8 bits: bank-2 ring-oscillator mux select.
REQ-012 Port ro_enable, output, 1 bit: oscillator/counter enable.
REQ-013 Port cnt_reset, output, 1 bit: active-high clear to the counter stage.
REQ-014 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 Port done, output, 1 bit: one-cycle completion pulse.
REQ-016 Port response, output, N_BITS bits: collected response word.
REQ-017 Port resp_valid, output, 1 bit: response holds a complete run.

Function
REQ-018 States: IDLE, CLR, RUN, CAPT, NEXT, DONE; every output is registered.
REQ-019 IDLE: start=1 latches chal_seed, clears index i and the shadow shift register, clears resp_valid, and moves to CLR on the next cycle.
REQ-020 start is ignored in every state except IDLE.
REQ-021 sel1 = {1'b0, (seed + 2*i) mod 128}; sel2 = {1'b0, (seed + 2*i + 1) mod 128}; 7-bit wrap-around; sel1 never equals sel2.
REQ-022 sel1 and sel2 update on entry to CLR and are stable through CLR, RUN and CAPT.
REQ-023 CLR: lasts SETTLE_CYC cycles, with cnt_reset=1 and ro_enable=0.
REQ-024 RUN: lasts exactly WIN_CYC cycles, with ro_enable=1 and cnt_reset=0.
REQ-025 CAPT: lasts SETTLE_CYC cycles, with ro_enable=0; cmp_bit is sampled on the last CAPT cycle into shadow bit i.
REQ-026 NEXT: one cycle; if i == N_BITS-1 go to DONE, else increment i and go to CLR.
REQ-027 Per-bit cost is exactly 2*SETTLE_CYC + WIN_CYC + 1 cycles.
REQ-028 If start is sampled at cycle 0, done is high at cycle N_BITS*(2*SETTLE_CYC+WIN_CYC+1)+1.
REQ-029 DONE: lasts one cycle; copies the shadow register to response, sets resp_valid=1, pulses done, then returns to IDLE.
REQ-030 response and resp_valid hold until the next accepted start or reset; intermediate bits never appear on response.
REQ-031 abort=1 in any non-IDLE state returns to IDLE next cycle, with ro_enable=0, cnt_reset=0 and done=0; response is unchanged and resp_valid stays 0.
REQ-032 abort has priority over every other transition; abort in IDLE has no effect.
REQ-033 If abort and start are both high in IDLE, start is accepted.

Reset
REQ-034 reset=0 asynchronously forces IDLE and zeroes: sel1, sel2, ro_enable, cnt_reset, busy, done, response, resp_valid, i, seed and the shadow register.
REQ-035 Reset asserted mid-run discards all partial results; no done pulse is produced.
REQ-036 After reset release, the first run starts only on a new start in IDLE.

Verification (bench parameters: N_BITS=4, WIN_CYC=8, SETTLE_CYC=2, so 13 cycles per bit)
REQ-037 Nominal run: start at cycle 0 with chal_seed=0x10 and cmp_bit pattern 1,0,1,1 per bit -> done at cycle 53, response=4'b1101, resp_valid=1.
REQ-038 Select and enable sequence: chal_seed=0x7F -> (sel1,sel2) per bit = (0x7F,0x00), (0x01,0x02), (0x03,0x04), (0x05,0x06); ro_enable high exactly 8 cycles per bit; cnt_reset high 2 cycles before each RUN.
REQ-039 Abort in RUN of bit 2 -> IDLE next cycle, ro_enable=0, done never pulses, resp_valid=0, response keeps the prior run's value.
REQ-040 Reset low during CAPT -> all outputs 0 immediately without waiting for clk; a new start then reproduces REQ-037 timing.
REQ-041 start held high for 60 cycles -> exactly one run accepted during busy; a second run starts at cycle 54, and resp_valid drops at that acceptance.
